axis_pkt_gen_chk: RTL and testbench
===================================

Name: axis_pkt_gen_chk

Overview:
- Parametrised AXI4-Stream traffic generator and checker pair for link and loopback testing on the 10G datapath.
- Generator emits sequence-numbered, rotating-pattern packets with runtime-configurable length, inter-frame gap and packet budget.
- Checker receives the looped-back stream and classifies each packet as good, corrupt or out-of-sequence.
- Control and status are plain ports; the AXI-Lite register block that drives them sits outside this module.

Parameters:
- C_DATA_WIDTH, 64, tdata width in bits; multiple of 64, at least 64.
- C_TUSER_WIDTH, 128, tuser width in bits; tuser is driven to 0 and ignored on input.
- C_LEN_WIDTH, 16, width of the packet-length, IFG and word-index fields.
- C_CNT_WIDTH, 32, width of every status counter.
- C_SEED, 64'hCAFEBEEFCAFEBEEF, pattern seed; replicated to fill C_DATA_WIDTH.

Ports:
- axi_aclk  in  1  clock for all logic.
- axi_aresetn  in  1  asynchronous, active-low reset.
- cfg_enable  in  1  level; generator runs while high.
- cfg_pkt_len  in  C_LEN_WIDTH  packet length in words; values below 2 are treated as 2.
- cfg_ifg_len  in  C_LEN_WIDTH  idle cycles between packets; 0 means back-to-back.
- cfg_num_pkts  in  C_CNT_WIDTH  packet budget; 0 means continuous.
- count_reset  in  1  synchronous clear of counters and sequence state.
- m_axis_tdata  out  C_DATA_WIDTH  generated data.
- m_axis_tstrb  out  C_DATA_WIDTH/8  all ones when tvalid is high, else 0.
- m_axis_tuser  out  C_TUSER_WIDTH  always 0.
- m_axis_tvalid  out  1  generator output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last word of the packet.
- s_axis_tdata  in  C_DATA_WIDTH  received data.
- s_axis_tstrb  in  C_DATA_WIDTH/8  received strobes; ignored.
- s_axis_tuser  in  C_TUSER_WIDTH  received tuser; ignored.
- s_axis_tvalid  in  1  received word valid.
- s_axis_tready  out  1  constant 1.
- s_axis_tlast  in  1  received last word.
- tx_count  out  C_CNT_WIDTH  packets fully sent.
- rx_count  out  C_CNT_WIDTH  good packets received.
- err_count  out  C_CNT_WIDTH  packets with a data or length error.
- seq_err_count  out  C_CNT_WIDTH  sequence discontinuities.
- gen_done  out  1  packet budget exhausted.

Behaviour:
- Reset values: all outputs 0 except s_axis_tready=1. gen_seq, chk_exp_seq and every counter are 0. Generator state is G_IDLE; checker state is C_IDLE.
- Pattern: S is C_SEED replicated to C_DATA_WIDTH. Word 0 is S XOR {zeros, seq[31:0]}. Word k is rotr(word k-1, 1).
- AXIS compliance: tdata, tlast and tstrb hold stable while tvalid=1 and tready=0. A word advances only on tvalid&&tready.
- Generator FSM:
  - G_IDLE: if cfg_enable && !gen_done, load word 0 and go to G_PKT. tvalid rises on the next cycle, so latency from enable is 1 cycle.
  - G_PKT: on each handshake, word index +1 and the rotated word is loaded. tlast=1 when index == len-1.
  - On the tlast handshake: tx_count+1, gen_seq+1. Go to G_IFG if cfg_ifg_len>0, else to G_PKT with the next word 0 presented on the following cycle (no bubble).
  - G_IFG: tvalid=0 for exactly cfg_ifg_len cycles, counted on the clock and independent of tready. Then go to G_PKT, or to G_IDLE if cfg_enable=0 or the budget is reached.
  - Budget reached means cfg_num_pkts!=0 && tx_count==cfg_num_pkts. gen_done then sets and stays set until count_reset.
  - cfg_enable falling mid-packet: the current packet completes; no truncation.
  - cfg_pkt_len and cfg_ifg_len are sampled at packet start only.
- Checker FSM:
  - C_IDLE: on a valid word, seq = tdata[31:0] XOR S[31:0]. Header is bad if the upper bits differ from S. Load expected next word = rotr(tdata,1), set index=1.
  - Sequence check: if seq != chk_exp_seq, seq_err_count+1. In all cases chk_exp_seq = seq+1, so the checker resyncs.
  - Go to C_DATA; if tlast arrives on word 0, it is a length error and the packet completes immediately.
  - C_DATA: each valid word is compared with the expected word; any mismatch latches bad. Then index+1 and the expected word rotates.
  - tlast with index != len-1 is a length error. Reaching index len-1 without tlast latches bad, and the checker consumes words until tlast.
  - Completion: in the cycle after tlast, rx_count+1 if clean, else err_count+1. Exactly one of the two increments per packet.
  - The checker uses cfg_pkt_len sampled at its own packet start.
- count_reset:
  - Clears all counters, gen_seq, chk_exp_seq and gen_done in the next cycle.
  - It wins over a simultaneous increment.
  - It does not abort an in-flight packet.
- Counters wrap at 2^C_CNT_WIDTH. The sequence field is 32 bits and wraps from FFFFFFFF to 0 without flagging a sequence error.
- Asynchronous reset mid-packet: tvalid drops immediately, there are no partial-packet counts, and the checker returns to C_IDLE.

Test Plan:
- Loopback m to s, len=16, ifg=5, num_pkts=10, tready=1 -> exactly 10 packets of 16 words; tlast on word 15; gaps of 5 cycles; tx_count=10, rx_count=10, err_count=0, seq_err_count=0, gen_done=1.
- Same setup with tready toggling randomly at 50% -> tdata and tlast stable while stalled; counts identical to the previous case.
- ifg=0, len=2, continuous for 100 cycles at tready=1 -> tvalid never drops between packets; rx_count equals tx_count at stop.
- Bit 3 of word 5 of packet 2 flipped on the return path -> err_count=1, rx_count=N-1, seq_err_count=0.
- Packet with seq 3 dropped on the return path -> seq_err_count=1, err_count=0; the checker resyncs and later packets count as good. Checker fed tlast at word 9 with len=16 -> err_count+1.
- count_reset pulsed on the same cycle as a tlast handshake -> tx_count=0 and the next packet carries seq 0. Asynchronous reset asserted mid-packet -> tvalid=0 immediately and all counters 0.

Source files
------------

// File: rtl/axis_pkt_gen_chk.sv
// AXI4-Stream packet generator plus loopback checker for link testing (seq-numbered rotating pattern).
// Latency: first tvalid 1 cycle after enable; checker counters update the cycle after the tlast beat.
// Backpressure: generator holds tdata/tlast/tstrb while stalled; checker is always ready and never stalls.
module axis_pkt_gen_chk #(
    parameter int          C_DATA_WIDTH  = 64,
    parameter int          C_TUSER_WIDTH = 128,
    parameter int          C_LEN_WIDTH   = 16,
    parameter int          C_CNT_WIDTH   = 32,
    parameter logic [63:0] C_SEED        = 64'hCAFEBEEFCAFEBEEF
) (
    input  logic                        axi_aclk,
    input  logic                        axi_aresetn,
    input  logic                        cfg_enable,
    input  logic [C_LEN_WIDTH-1:0]      cfg_pkt_len,
    input  logic [C_LEN_WIDTH-1:0]      cfg_ifg_len,
    input  logic [C_CNT_WIDTH-1:0]      cfg_num_pkts,
    input  logic                        count_reset,
    output logic [C_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0]   m_axis_tstrb,
    output logic [C_TUSER_WIDTH-1:0]    m_axis_tuser,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    input  logic [C_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_DATA_WIDTH/8-1:0]   s_axis_tstrb,
    input  logic [C_TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    output logic [C_CNT_WIDTH-1:0]      tx_count,
    output logic [C_CNT_WIDTH-1:0]      rx_count,
    output logic [C_CNT_WIDTH-1:0]      err_count,
    output logic [C_CNT_WIDTH-1:0]      seq_err_count,
    output logic                        gen_done
);
    localparam int                      W       = C_DATA_WIDTH;
    localparam logic [W-1:0]            SEED_W  = {(W/64){C_SEED}};
    localparam logic [C_LEN_WIDTH-1:0]  ONE_L   = C_LEN_WIDTH'(1);
    localparam logic [C_LEN_WIDTH-1:0]  MIN_LEN = C_LEN_WIDTH'(2);
    localparam logic [C_CNT_WIDTH-1:0]  ONE_C   = C_CNT_WIDTH'(1);

    typedef enum logic [1:0] {G_IDLE, G_PKT, G_IFG} gen_state_t;
    typedef enum logic       {C_IDLE, C_DATA}       chk_state_t;

    function automatic logic [W-1:0] rotr1(input logic [W-1:0] x);
        return {x[0], x[W-1:1]};
    endfunction

    function automatic logic [W-1:0] word0(input logic [31:0] seq);
        return SEED_W ^ {{(W-32){1'b0}}, seq};
    endfunction

    function automatic logic [C_LEN_WIDTH-1:0] eff_len(input logic [C_LEN_WIDTH-1:0] l);
        return (l < MIN_LEN) ? MIN_LEN : l;
    endfunction

    gen_state_t             gen_state;
    logic [W-1:0]           gen_data;
    logic                   gen_vld;
    logic                   gen_last;
    logic [C_LEN_WIDTH-1:0] gen_idx;
    logic [C_LEN_WIDTH-1:0] gen_len;
    logic [C_LEN_WIDTH-1:0] gen_ifg;
    logic [C_LEN_WIDTH-1:0] ifg_cnt;
    logic [31:0]            gen_seq;
    logic [C_CNT_WIDTH-1:0] tx_cnt;
    logic                   done;

    logic                   gen_hs;
    logic                   budget_next;
    logic                   gen_load;
    logic [31:0]            load_seq;
    logic                   unused_in;

    assign gen_hs        = gen_vld && m_axis_tready;
    // Budget check for the packet finishing this cycle; a concurrent count_reset restarts the budget.
    assign budget_next   = (cfg_num_pkts != '0) && ((tx_cnt + ONE_C) == cfg_num_pkts) && !count_reset;

    assign m_axis_tdata  = gen_data;
    assign m_axis_tvalid = gen_vld;
    assign m_axis_tlast  = gen_last;
    assign m_axis_tstrb  = {(W/8){gen_vld}};
    assign m_axis_tuser  = '0;
    assign s_axis_tready = 1'b1;
    assign tx_count      = tx_cnt;
    assign gen_done      = done;
    assign unused_in     = ^{s_axis_tstrb, s_axis_tuser};

    // Decide when a new packet's word 0 is loaded and which sequence number it carries.
    always_comb begin
        gen_load = 1'b0;
        load_seq = count_reset ? 32'd0 : gen_seq;
        case (gen_state)
            G_IDLE: gen_load = cfg_enable && !done;
            G_PKT: begin
                gen_load = gen_hs && gen_last && (gen_ifg == '0) && cfg_enable && !budget_next;
                load_seq = count_reset ? 32'd0 : gen_seq + 32'd1;
            end
            G_IFG:  gen_load = (ifg_cnt == ONE_L) && cfg_enable && !done;
            default: gen_load = 1'b0;
        endcase
    end

    // Generator FSM: word sequencing, tlast and inter-frame gap timing.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            gen_state <= G_IDLE;
            gen_data  <= '0;
            gen_vld   <= 1'b0;
            gen_last  <= 1'b0;
            gen_idx   <= '0;
            gen_len   <= '0;
            gen_ifg   <= '0;
            ifg_cnt   <= '0;
        end else if (gen_load) begin
            gen_state <= G_PKT;
            gen_data  <= word0(load_seq);
            gen_vld   <= 1'b1;
            gen_last  <= 1'b0;
            gen_idx   <= '0;
            gen_len   <= eff_len(cfg_pkt_len);
            gen_ifg   <= cfg_ifg_len;
        end else begin
            case (gen_state)
                G_PKT: begin
                    if (gen_hs) begin
                        if (gen_last) begin
                            gen_vld  <= 1'b0;
                            gen_last <= 1'b0;
                            if (gen_ifg != '0) begin
                                ifg_cnt   <= gen_ifg;
                                gen_state <= G_IFG;
                            end else begin
                                gen_state <= G_IDLE;
                            end
                        end else begin
                            gen_idx  <= gen_idx + ONE_L;
                            gen_data <= rotr1(gen_data);
                            gen_last <= (gen_idx + ONE_L) == (gen_len - ONE_L);
                        end
                    end
                end
                G_IFG: begin
                    if (ifg_cnt <= ONE_L) gen_state <= G_IDLE;
                    else                  ifg_cnt   <= ifg_cnt - ONE_L;
                end
                default: ;
            endcase
        end
    end

    // Generator counters and budget flag; count_reset overrides any increment.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            tx_cnt  <= '0;
            gen_seq <= '0;
            done    <= 1'b0;
        end else if (count_reset) begin
            tx_cnt  <= '0;
            gen_seq <= '0;
            done    <= 1'b0;
        end else if (gen_hs && gen_last) begin
            tx_cnt  <= tx_cnt + ONE_C;
            gen_seq <= gen_seq + 32'd1;
            if (budget_next) done <= 1'b1;
        end
    end

    chk_state_t             chk_state;
    logic [W-1:0]           chk_exp;
    logic [C_LEN_WIDTH-1:0] chk_idx;
    logic [C_LEN_WIDTH-1:0] chk_len;
    logic                   chk_bad;
    logic [31:0]            chk_exp_seq;
    logic [C_CNT_WIDTH-1:0] rx_cnt;
    logic [C_CNT_WIDTH-1:0] err_cnt;
    logic [C_CNT_WIDTH-1:0] seq_cnt;

    logic [31:0]            rx_seq;
    logic                   hdr_bad;
    logic                   word_bad;
    logic                   at_last_idx;
    logic                   end_bad;

    assign rx_seq        = s_axis_tdata[31:0] ^ SEED_W[31:0];
    assign hdr_bad       = s_axis_tdata[W-1:32] != SEED_W[W-1:32];
    assign word_bad      = s_axis_tdata != chk_exp;
    assign at_last_idx   = chk_idx == (chk_len - ONE_L);
    // tlast on word 0 is always a length error; later, any latched or current fault or wrong length.
    assign end_bad       = (chk_state == C_IDLE) ? 1'b1 : (chk_bad || word_bad || !at_last_idx);
    assign rx_count      = rx_cnt;
    assign err_count     = err_cnt;
    assign seq_err_count = seq_cnt;

    // Checker FSM: header decode on word 0, then expected-word tracking until tlast.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            chk_state <= C_IDLE;
            chk_exp   <= '0;
            chk_idx   <= '0;
            chk_len   <= '0;
            chk_bad   <= 1'b0;
        end else if (s_axis_tvalid) begin
            case (chk_state)
                C_IDLE: begin
                    if (!s_axis_tlast) begin
                        chk_exp   <= rotr1(s_axis_tdata);
                        chk_idx   <= ONE_L;
                        chk_bad   <= hdr_bad;
                        chk_len   <= eff_len(cfg_pkt_len);
                        chk_state <= C_DATA;
                    end
                end
                default: begin
                    if (s_axis_tlast) begin
                        chk_state <= C_IDLE;
                    end else begin
                        chk_exp <= rotr1(chk_exp);
                        chk_idx <= chk_idx + ONE_L;
                        chk_bad <= chk_bad || word_bad || at_last_idx;
                    end
                end
            endcase
        end
    end

    // Checker counters and sequence tracking; resync to every received header.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            chk_exp_seq <= '0;
            rx_cnt      <= '0;
            err_cnt     <= '0;
            seq_cnt     <= '0;
        end else if (count_reset) begin
            chk_exp_seq <= '0;
            rx_cnt      <= '0;
            err_cnt     <= '0;
            seq_cnt     <= '0;
        end else if (s_axis_tvalid) begin
            if (chk_state == C_IDLE) begin
                chk_exp_seq <= rx_seq + 32'd1;
                if (rx_seq != chk_exp_seq) seq_cnt <= seq_cnt + ONE_C;
            end
            if (s_axis_tlast) begin
                if (end_bad) err_cnt <= err_cnt + ONE_C;
                else         rx_cnt  <= rx_cnt + ONE_C;
            end
        end
    end
endmodule

// File: tb/tb_axis_pkt_gen_chk.sv
module tb_axis_pkt_gen_chk;
    localparam logic [63:0] SEED = 64'hCAFEBEEFCAFEBEEF;

    logic        axi_aclk = 1'b0;
    logic        axi_aresetn;
    logic        cfg_enable;
    logic [15:0] cfg_pkt_len;
    logic [15:0] cfg_ifg_len;
    logic [31:0] cfg_num_pkts;
    logic        count_reset;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tstrb;
    logic [127:0] m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tstrb;
    logic [127:0] s_axis_tuser;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [31:0] tx_count, rx_count, err_count, seq_err_count;
    logic        gen_done;

    int checks = 0;
    int errors = 0;

    // Return-path controls (written by the stimulus only)
    bit          src_tb, flip_en, drop_en, rand_ready, chk_on, gap_chk;
    int          flip_pkt, flip_word, drop_pkt, exp_len, exp_gap;
    logic        tb_vld, tb_last;
    logic [63:0] tb_dat;

    // Monitor state (written by the monitor only)
    int          mon_word, mon_pkt, gap;
    logic [31:0] mon_seq;
    bit          mon_hs, mon_hs_last, in_gap, prev_stall, prev_last;
    logic [63:0] prev_data;

    always #5 axi_aclk = ~axi_aclk;

    axis_pkt_gen_chk dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .cfg_enable(cfg_enable),
        .cfg_pkt_len(cfg_pkt_len), .cfg_ifg_len(cfg_ifg_len), .cfg_num_pkts(cfg_num_pkts),
        .count_reset(count_reset),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .tx_count(tx_count), .rx_count(rx_count), .err_count(err_count),
        .seq_err_count(seq_err_count), .gen_done(gen_done)
    );

    // Loopback with optional bit flip / packet drop, or a bench-driven stream.
    assign s_axis_tvalid = src_tb ? tb_vld :
                           (m_axis_tvalid && m_axis_tready && !(drop_en && mon_pkt == drop_pkt));
    assign s_axis_tdata  = src_tb ? tb_dat :
                           (m_axis_tdata ^ ((flip_en && mon_pkt == flip_pkt && mon_word == flip_word) ? 64'h8 : 64'h0));
    assign s_axis_tlast  = src_tb ? tb_last : m_axis_tlast;
    assign s_axis_tstrb  = 8'hFF;
    assign s_axis_tuser  = '0;

    // Reference pattern: word k of packet seq is (SEED ^ seq) rotated right by k bits.
    function automatic logic [63:0] model_word(input logic [31:0] seq, input int k);
        logic [63:0] w;
        int r;
        w = SEED ^ {32'd0, seq};
        r = k % 64;
        if (r == 0) return w;
        return (w >> r) | (w << (64 - r));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transmit-side monitor: drives tready, checks pattern, tlast, stall stability and gaps.
    always @(negedge axi_aclk) begin
        if (!axi_aresetn) begin
            mon_word = 0; mon_pkt = 0; mon_seq = 0; gap = 0;
            mon_hs = 0; mon_hs_last = 0; in_gap = 0; prev_stall = 0; prev_last = 0;
            prev_data = '0;
            m_axis_tready = 1'b1;
        end else begin
            if (mon_hs) begin
                if (mon_hs_last) begin
                    mon_pkt++; mon_word = 0; mon_seq++; in_gap = 1; gap = 0;
                end else begin
                    mon_word++;
                end
            end
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall) begin
                chk("stall_vld", {63'd0, m_axis_tvalid}, 64'd1);
                chk("stall_dat", m_axis_tdata, prev_data);
                chk("stall_last", {63'd0, m_axis_tlast}, {63'd0, prev_last});
            end
            if (m_axis_tvalid) begin
                if (in_gap && gap_chk) chk("ifg", gap, exp_gap);
                in_gap = 0;
                if (chk_on) begin
                    chk("word", m_axis_tdata, model_word(mon_seq, mon_word));
                    chk("tlast", {63'd0, m_axis_tlast}, {63'd0, mon_word == exp_len - 1});
                end
                mon_hs      = m_axis_tready;
                mon_hs_last = m_axis_tlast;
                prev_stall  = !m_axis_tready;
                prev_data   = m_axis_tdata;
                prev_last   = m_axis_tlast;
            end else begin
                if (in_gap) gap++;
                mon_hs = 0; prev_stall = 0;
            end
        end
    end

    task automatic do_reset();
        axi_aresetn = 1'b0;
        cfg_enable = 0; count_reset = 0;
        src_tb = 0; flip_en = 0; drop_en = 0; rand_ready = 0; chk_on = 1; gap_chk = 0;
        tb_vld = 0; tb_last = 0; tb_dat = '0;
        repeat (3) @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!gen_done && n < budget) begin
            @(negedge axi_aclk);
            n++;
        end
        chk("gen_done_timeout", {63'd0, gen_done}, 64'd1);
    endtask

    task automatic send_pkt(input logic [31:0] seq, input int nwords);
        for (int k = 0; k < nwords; k++) begin
            tb_vld = 1; tb_dat = model_word(seq, k); tb_last = (k == nwords - 1);
            @(negedge axi_aclk);
        end
        tb_vld = 0; tb_last = 0;
        @(negedge axi_aclk);
    endtask

    task automatic run_budget(input int len, input int ifg, input int num, input bit rr, input int budget);
        cfg_pkt_len = 16'(len); cfg_ifg_len = 16'(ifg); cfg_num_pkts = 32'(num);
        exp_len = (len < 2) ? 2 : len; exp_gap = ifg; gap_chk = 1; rand_ready = rr;
        cfg_enable = 1;
        wait_done(budget);
        repeat (10) @(negedge axi_aclk);
    endtask

    initial begin
        int n;
        cfg_pkt_len = 16; cfg_ifg_len = 5; cfg_num_pkts = 10;
        exp_len = 16; exp_gap = 5; flip_pkt = 0; flip_word = 0; drop_pkt = 0;
        do_reset();

        // Reset state
        chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("rst_tdata", m_axis_tdata, 64'd0);
        chk("rst_tstrb", {56'd0, m_axis_tstrb}, 64'd0);
        chk("rst_s_tready", {63'd0, s_axis_tready}, 64'd1);
        chk("rst_counts", {tx_count | rx_count | err_count | seq_err_count}, 64'd0);
        chk("rst_done", {63'd0, gen_done}, 64'd0);

        // Loopback len=16 ifg=5 num=10, tready=1
        run_budget(16, 5, 10, 0, 600);
        chk("t1_tx", tx_count, 10);
        chk("t1_rx", rx_count, 10);
        chk("t1_err", err_count, 0);
        chk("t1_seq", seq_err_count, 0);
        chk("t1_mon_pkts", mon_pkt, 10);
        chk("t1_idle", {63'd0, m_axis_tvalid}, 64'd0);

        // Same with random tready
        do_reset();
        run_budget(16, 5, 10, 1, 3000);
        chk("t2_tx", tx_count, 10);
        chk("t2_rx", rx_count, 10);
        chk("t2_err", err_count, 0);
        chk("t2_seq", seq_err_count, 0);
        chk("t2_mon_pkts", mon_pkt, 10);
        rand_ready = 0;

        // Continuous back-to-back, len=2
        do_reset();
        cfg_pkt_len = 2; cfg_ifg_len = 0; cfg_num_pkts = 0; exp_len = 2; exp_gap = 0; gap_chk = 1;
        cfg_enable = 1;
        repeat (100) @(negedge axi_aclk);
        cfg_enable = 0;
        repeat (20) @(negedge axi_aclk);
        chk("t3_rx_eq_tx", rx_count, {32'd0, tx_count});
        chk("t3_tx_mon", tx_count, mon_pkt);
        chk("t3_many", {63'd0, tx_count >= 45}, 64'd1);
        chk("t3_err", err_count, 0);
        chk("t3_done", {63'd0, gen_done}, 64'd0);

        // Length below 2 treated as 2
        do_reset();
        run_budget(1, 1, 3, 0, 200);
        chk("t4_tx", tx_count, 3);
        chk("t4_rx", rx_count, 3);
        chk("t4_err", err_count, 0);

        // Bit 3 of word 5 of packet 2 flipped
        do_reset();
        flip_en = 1; flip_pkt = 2; flip_word = 5;
        run_budget(16, 2, 6, 0, 600);
        chk("t5_tx", tx_count, 6);
        chk("t5_err", err_count, 1);
        chk("t5_rx", rx_count, 5);
        chk("t5_seq", seq_err_count, 0);

        // Packet with seq 3 dropped
        do_reset();
        drop_en = 1; drop_pkt = 3;
        run_budget(16, 2, 6, 0, 600);
        chk("t6_seq", seq_err_count, 1);
        chk("t6_err", err_count, 0);
        chk("t6_rx", rx_count, 5);

        // Bench-driven checker stream: short, long, single-word, sequence wrap
        do_reset();
        src_tb = 1; cfg_pkt_len = 16;
        send_pkt(32'd0, 10);
        chk("t7_short_err", err_count, 1);
        send_pkt(32'd1, 16);
        chk("t7_good_rx", rx_count, 1);
        send_pkt(32'd2, 1);
        chk("t7_word0_last", err_count, 2);
        send_pkt(32'hFFFFFFFF, 16);
        chk("t7_jump_seq", seq_err_count, 1);
        send_pkt(32'd0, 16);
        chk("t7_wrap_seq", seq_err_count, 1);
        chk("t7_wrap_rx", rx_count, 3);
        send_pkt(32'd1, 18);
        chk("t7_long_err", err_count, 3);
        chk("t7_long_rx", rx_count, 3);
        src_tb = 0;

        // count_reset on the tlast handshake of the third packet
        do_reset();
        chk_on = 0;
        cfg_pkt_len = 4; cfg_ifg_len = 0; cfg_num_pkts = 0; exp_len = 4; exp_gap = 0; gap_chk = 1;
        cfg_enable = 1;
        n = 0;
        while (!(m_axis_tvalid && m_axis_tlast && tx_count == 2) && n < 200) begin
            @(negedge axi_aclk);
            n++;
        end
        chk("t8_reach_tlast", {63'd0, n < 200}, 64'd1);
        count_reset = 1;
        @(negedge axi_aclk);
        count_reset = 0;
        chk("t8_tx_cleared", tx_count, 0);
        chk("t8_seq0_word", m_axis_tdata, SEED);
        chk("t8_seq0_vld", {63'd0, m_axis_tvalid}, 64'd1);
        repeat (4) @(negedge axi_aclk);
        chk("t8_seq1_word", m_axis_tdata, SEED ^ 64'd1);
        chk("t8_tx_after", tx_count, 1);
        chk("t8_no_seq_err", seq_err_count, 0);

        // Asynchronous reset mid-packet
        do_reset();
        cfg_pkt_len = 16; cfg_ifg_len = 0; cfg_num_pkts = 0; exp_len = 16;
        cfg_enable = 1;
        repeat (24) @(negedge axi_aclk);
        chk("t9_running", {63'd0, m_axis_tvalid}, 64'd1);
        #2 axi_aresetn = 1'b0;
        #1;
        chk("t9_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("t9_tlast", {63'd0, m_axis_tlast}, 64'd0);
        chk("t9_counts", {tx_count | rx_count | err_count | seq_err_count}, 64'd0);
        cfg_enable = 0;
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        repeat (3) @(negedge axi_aclk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
